// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet receiver.
package mouse_pkg;

  // Frame-level FSM: waiting for a start bit, or collecting the 11-bit frame.
  typedef enum logic {
    IDLE,
    SHIFT
  } frame_state_t;

  // Packet-level FSM: which of the three movement-packet bytes is expected next.
  typedef enum logic [1:0] {
    B1,
    B2,
    B3
  } pkt_state_t;

  localparam int PS2_FRAME_BITS = 11;

  // Byte 1 bit positions.
  localparam int B1_SYNC  = 3;
  localparam int B1_XSIGN = 4;
  localparam int B1_YSIGN = 5;

  // Frame layout, LSB first: [0] start, [8:1] data, [9] parity, [10] stop.
  // Odd parity means d0..d7 together with the parity bit XOR to 1.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] frame,
                                    input logic                      parity_en);
    frame_ok = !frame[0] && frame[10] && (!parity_en || (^frame[9:1]));
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin conditioning: 2-FF synchronizers on clock and data, a debounce
// filter on the clock, and a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c,
  input  logic ps2d,
  output logic d_sync,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             c_meta;
  logic             c_sync;
  logic             d_meta;
  logic             c_filt;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // Synchronize both asynchronous pins; reset to the idle-high bus level so
  // leaving reset never looks like a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c;
      c_sync <= c_meta;
      d_meta <= ps2d;
      d_sync <= d_meta;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign settle = (c_sync != c_filt) && (cnt == CNT_W'(FILTER_LEN - 1));

  // Debounce the clock and emit a registered pulse on each accepted high-to-low change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_filt <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      fall <= settle && !c_sync;
      if (c_sync == c_filt) begin
        cnt <= '0;
      end else if (settle) begin
        c_filt <= c_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mouse_packet_rx.sv
// PS/2 mouse packet receiver: assembles the 3-byte movement packet into
// 9-bit two's-complement deltas and button state.
// Optional feature: define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module mouse_packet_rx
  import mouse_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [8:0] xChange,
  output logic [8:0] yChange,
  output logic [2:0] btn,
  output logic       m_done_tick,
  output logic       rx_err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                      d_sync;
  logic                      fall;
  frame_state_t              frame_state;
  pkt_state_t                pkt_state;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-1:0] frame_q;
  logic                      byte_rdy;
  logic                      byte_ok;
  logic [7:0]                byte_data;
  logic [TO_W-1:0]           to_cnt;
  logic                      to_active;
  logic                      timeout;
  logic [2:0]                b1_btn;
  logic                      b1_xsign;
  logic                      b1_ysign;
  logic [7:0]                x_byte;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .d_sync (d_sync),
    .fall   (fall)
  );

  // byte_rdy is high the cycle after the stop-bit fall, when frame_q is complete.
  assign byte_ok   = frame_ok(frame_q, PARITY_EN);
  assign byte_data = frame_q[8:1];

  // The watchdog runs only while something is partially received; a fall in
  // the same cycle always takes precedence over the abort.
  assign to_active = (frame_state == SHIFT) || (pkt_state != B1);
  assign timeout   = to_active && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared by every fall and whenever nothing is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (fall || !to_active || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Frame FSM: shift in start, d0..d7, parity, stop on successive falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_state <= IDLE;
      bit_cnt     <= '0;
      frame_q     <= '0;
      byte_rdy    <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      if (timeout) begin
        frame_state <= IDLE;
        bit_cnt     <= '0;
      end else if (fall) begin
        case (frame_state)
          IDLE: begin
            if (rx_en) begin
              frame_q     <= {d_sync, frame_q[PS2_FRAME_BITS-1:1]};
              bit_cnt     <= 4'd1;
              frame_state <= SHIFT;
            end
          end
          SHIFT: begin
            frame_q <= {d_sync, frame_q[PS2_FRAME_BITS-1:1]};
            if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
              bit_cnt     <= '0;
              byte_rdy    <= 1'b1;
              frame_state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: frame_state <= IDLE;
        endcase
      end
    end
  end

  // Packet FSM: latch header, X and Y bytes, then publish outputs with a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_state   <= B1;
      b1_btn      <= '0;
      b1_xsign    <= 1'b0;
      b1_ysign    <= 1'b0;
      x_byte      <= '0;
      xChange     <= '0;
      yChange     <= '0;
      btn         <= '0;
      m_done_tick <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      m_done_tick <= 1'b0;
      rx_err      <= 1'b0;
      if (timeout) begin
        pkt_state <= B1;
        rx_err    <= 1'b1;
      end else if (byte_rdy) begin
        if (!byte_ok) begin
          pkt_state <= B1;
          rx_err    <= 1'b1;
        end else begin
          case (pkt_state)
            B1: begin
              // A header without the always-one sync bit means we are out of
              // step with the mouse; drop it and wait for a real header.
              if (byte_data[B1_SYNC]) begin
                b1_btn    <= byte_data[2:0];
                b1_xsign  <= byte_data[B1_XSIGN];
                b1_ysign  <= byte_data[B1_YSIGN];
                pkt_state <= B2;
              end
            end
            B2: begin
              x_byte    <= byte_data;
              pkt_state <= B3;
            end
            B3: begin
              xChange     <= {b1_xsign, x_byte};
              yChange     <= {b1_ysign, byte_data};
              btn         <= b1_btn;
              m_done_tick <= 1'b1;
              pkt_state   <= B1;
            end
            default: pkt_state <= B1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_rx.sv
// Directed testbench for mouse_packet_rx: drives PS/2 frames on the pins and
// checks decoded packets, error pulses, timeout and reset behaviour.
module tb_mouse_packet_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF_BIT       = 40;
  localparam int BYTE_GAP       = 200;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2c    = 1'b1;
  logic       ps2d    = 1'b1;
  logic       rx_en   = 1'b1;
  logic [8:0] xChange;
  logic [8:0] yChange;
  logic [2:0] btn;
  logic       m_done_tick;
  logic       rx_err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  mouse_packet_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .rx_en      (rx_en),
    .xChange    (xChange),
    .yChange    (yChange),
    .btn        (btn),
    .m_done_tick(m_done_tick),
    .rx_err     (rx_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_done_tick) done_cnt++;
    if (rx_err) err_cnt++;
    if (m_done_tick && rx_err) both_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nbits of a frame; bad_par flips the odd-parity bit.
  task automatic send_bits(input logic [7:0] data, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_clks(HALF_BIT / 2);
      ps2c = 1'b0;
      wait_clks(HALF_BIT);
      ps2c = 1'b1;
      wait_clks(HALF_BIT / 2);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic bad_par);
    send_bits(data, bad_par, 11);
    ps2d = 1'b1;
    wait_clks(BYTE_GAP);
  endtask

  task automatic send_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clks(5);
    checks++; if (xChange !== 9'h000) begin errors++; $display("FAIL reset_x: got %h expected %h", xChange, 9'h000); end
    checks++; if (yChange !== 9'h000) begin errors++; $display("FAIL reset_y: got %h expected %h", yChange, 9'h000); end
    checks++; if (btn !== 3'b000) begin errors++; $display("FAIL reset_btn: got %b expected %b", btn, 3'b000); end
    checks++; if (m_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", m_done_tick); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rx_err); end
    reset_n = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_basic();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_packet(8'h08, 8'h05, 8'h03);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (xChange !== 9'h005) begin errors++; $display("FAIL basic_x: got %h expected %h", xChange, 9'h005); end
    checks++; if (yChange !== 9'h003) begin errors++; $display("FAIL basic_y: got %h expected %h", yChange, 9'h003); end
    checks++; if (btn !== 3'b000) begin errors++; $display("FAIL basic_btn: got %b expected %b", btn, 3'b000); end
  endtask

  task automatic test_negative();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_packet(8'h39, 8'hFB, 8'hFE);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL neg_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL neg_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (xChange !== 9'h1FB) begin errors++; $display("FAIL neg_x: got %h expected %h", xChange, 9'h1FB); end
    checks++; if (yChange !== 9'h1FE) begin errors++; $display("FAIL neg_y: got %h expected %h", yChange, 9'h1FE); end
    checks++; if (btn !== 3'b001) begin errors++; $display("FAIL neg_btn: got %b expected %b", btn, 3'b001); end
  endtask

  task automatic test_parity();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    send_byte(8'h03, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    // Bad byte 2 aborts; the trailing 0x03 lacks the sync bit and is dropped.
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL par_err: got %0d expected 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL par_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (xChange !== 9'h1FB) begin errors++; $display("FAIL par_x_hold: got %h expected %h", xChange, 9'h1FB); end
    checks++; if (yChange !== 9'h1FE) begin errors++; $display("FAIL par_y_hold: got %h expected %h", yChange, 9'h1FE); end
    checks++; if (btn !== 3'b001) begin errors++; $display("FAIL par_btn_hold: got %b expected %b", btn, 3'b001); end
`else
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL par_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL par_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (xChange !== 9'h005) begin errors++; $display("FAIL par_x: got %h expected %h", xChange, 9'h005); end
    checks++; if (yChange !== 9'h003) begin errors++; $display("FAIL par_y: got %h expected %h", yChange, 9'h003); end
`endif
    d0 = done_cnt; e0 = err_cnt;
    send_packet(8'h08, 8'h01, 8'h01);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL par_next_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL par_next_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (xChange !== 9'h001) begin errors++; $display("FAIL par_next_x: got %h expected %h", xChange, 9'h001); end
    checks++; if (yChange !== 9'h001) begin errors++; $display("FAIL par_next_y: got %h expected %h", yChange, 9'h001); end
  endtask

  task automatic test_resync();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00, 1'b0);
    send_packet(8'h08, 8'h02, 8'h04);
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL resync_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL resync_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (xChange !== 9'h002) begin errors++; $display("FAIL resync_x: got %h expected %h", xChange, 9'h002); end
    checks++; if (yChange !== 9'h004) begin errors++; $display("FAIL resync_y: got %h expected %h", yChange, 9'h004); end
  endtask

  task automatic test_rx_en();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    rx_en = 1'b0;
    send_packet(8'h08, 8'h05, 8'h03);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rxen_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rxen_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (xChange !== 9'h002) begin errors++; $display("FAIL rxen_x_hold: got %h expected %h", xChange, 9'h002); end
    rx_en = 1'b1;
  endtask

  task automatic test_timeout();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    wait_clks(TIMEOUT_CYCLES + 10);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL to_err: got %0d expected 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL to_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (xChange !== 9'h002) begin errors++; $display("FAIL to_x_hold: got %h expected %h", xChange, 9'h002); end
    send_packet(8'h08, 8'h07, 8'h09);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL to_next_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL to_next_err: got %0d expected 1", err_cnt - e0); end
    checks++; if (xChange !== 9'h007) begin errors++; $display("FAIL to_next_x: got %h expected %h", xChange, 9'h007); end
    checks++; if (yChange !== 9'h009) begin errors++; $display("FAIL to_next_y: got %h expected %h", yChange, 9'h009); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    send_byte(8'h08, 1'b0);
    send_bits(8'h03, 1'b0, 5);
    reset_n = 1'b0;
    #1;
    checks++; if (xChange !== 9'h000) begin errors++; $display("FAIL rstmid_x: got %h expected %h", xChange, 9'h000); end
    checks++; if (yChange !== 9'h000) begin errors++; $display("FAIL rstmid_y: got %h expected %h", yChange, 9'h000); end
    checks++; if (btn !== 3'b000) begin errors++; $display("FAIL rstmid_btn: got %b expected %b", btn, 3'b000); end
    wait_clks(5);
    ps2c = 1'b1;
    ps2d = 1'b1;
    reset_n = 1'b1;
    wait_clks(BYTE_GAP);
    d0 = done_cnt; e0 = err_cnt;
    send_packet(8'h18, 8'h03, 8'h01);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (xChange !== 9'h103) begin errors++; $display("FAIL rstmid_x: got %h expected %h", xChange, 9'h103); end
    checks++; if (yChange !== 9'h001) begin errors++; $display("FAIL rstmid_y2: got %h expected %h", yChange, 9'h001); end
    checks++; if (btn !== 3'b000) begin errors++; $display("FAIL rstmid_btn2: got %b expected %b", btn, 3'b000); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_parity();
    test_resync();
    test_rx_en();
    test_timeout();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
